// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm trigger block.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int DIGIT_W     = 4;
  localparam int SEC_PER_MIN = 60;

  // {HR1,HR0,MIN1,MIN0}, one BCD digit per field
  typedef struct packed {
    logic [DIGIT_W-1:0] hr1;
    logic [DIGIT_W-1:0] hr0;
    logic [DIGIT_W-1:0] min1;
    logic [DIGIT_W-1:0] min0;
  } bcd_time_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_trigger_tone_gen.sv
// Buzzer tone generator: BEEP_DIV half-period divider plus optional
// once-per-second cadence gate (ALARM_CADENCE_EN).
module tone_gen #(
  parameter int BEEP_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sec_tick,
  output logic tone_out
);

  localparam int DW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

  logic [DW-1:0] div;
  logic          tone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      tone <= 1'b0;
    end else if (!run) begin
      div  <= '0;
      tone <= 1'b0;
    end else if (div == DW'(BEEP_DIV - 1)) begin
      div  <= '0;
      tone <= ~tone;
    end else begin
      div  <= div + DW'(1);
    end
  end

`ifdef ALARM_CADENCE_EN
  // Idles at 1 so every ring burst opens with an audible second.
  logic gate;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               gate <= 1'b1;
    else if (!run)         gate <= 1'b1;
    else if (sec_tick)     gate <= ~gate;
  end

  assign tone_out = tone & gate;
`else
  logic unused_sec_tick;
  assign unused_sec_tick = sec_tick;
  assign tone_out        = tone;
`endif

endmodule

// File: rtl/alarm_trigger.sv
// Alarm compare + ring/snooze/dismiss FSM driving buzzer and status.
// Optional beep-pause cadence selected by ALARM_CADENCE_EN.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZE     = 3,
  parameter int BEEP_DIV       = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] clock_time,
  input  logic [15:0] alarm_time,
  input  logic        sec_tick,
  input  logic        alarm_en,
  input  logic        load_active,
  input  logic        snooze,
  input  logic        dismiss,
  output logic        ringing,
  output logic        snoozed,
  output logic        buzzer,
  output logic [1:0]  snooze_cnt
);

  localparam int SNOOZE_S = SNOOZE_MIN * SEC_PER_MIN;
  localparam int CW       = $clog2(max_int(SNOOZE_S, RING_TIMEOUT_S) + 1);

  localparam logic [CW-1:0] SNOOZE_LIM = CW'(SNOOZE_S);
  localparam logic [CW-1:0] RING_LIM   = CW'(RING_TIMEOUT_S);
  localparam logic [1:0]    SNZ_CAP    = 2'(MAX_SNOOZE);

  alarm_state_t  st, st_n;
  logic [CW-1:0] sec_cnt, sec_n;
  logic [1:0]    snz_n;
  bcd_time_t     now_t, alm_t;
  logic          match, match_q, rise;
  logic          tone_out;

  assign now_t = clock_time;
  assign alm_t = alarm_time;
  assign match = (now_t == alm_t) && !load_active;
  // Edge-only trigger: arming or dismissing inside the match minute stays quiet.
  assign rise  = match && !match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      sec_cnt    <= '0;
      snooze_cnt <= '0;
      match_q    <= 1'b0;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      st         <= st_n;
      sec_cnt    <= sec_n;
      snooze_cnt <= snz_n;
      match_q    <= match;
      ringing    <= (st == RINGING);
      snoozed    <= (st == SNOOZE);
      buzzer     <= (st == RINGING) && tone_out;
    end
  end

  always_comb begin
    st_n  = st;
    sec_n = sec_cnt;
    snz_n = snooze_cnt;
    if (!alarm_en) begin
      st_n  = IDLE;
      sec_n = '0;
      snz_n = '0;
    end else begin
      unique case (st)
        IDLE: st_n = ARMED;
        ARMED: begin
          if (rise) begin
            st_n  = RINGING;
            sec_n = '0;
          end
        end
        RINGING: begin
          if (dismiss) begin
            st_n  = ARMED;
            snz_n = '0;
          end else if (snooze && (snooze_cnt < SNZ_CAP)) begin
            st_n  = SNOOZE;
            snz_n = snooze_cnt + 2'd1;
            sec_n = '0;
          end else if (sec_cnt >= RING_LIM) begin
            st_n  = ARMED;
            snz_n = '0;
          end else if (sec_tick) begin
            sec_n = sec_cnt + CW'(1);
          end
        end
        SNOOZE: begin
          if (dismiss) begin
            st_n  = ARMED;
            snz_n = '0;
          end else if (sec_cnt >= SNOOZE_LIM) begin
            st_n  = RINGING;
            sec_n = '0;
          end else if (sec_tick) begin
            sec_n = sec_cnt + CW'(1);
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  tone_gen #(.BEEP_DIV(BEEP_DIV)) u_tone (
    .clk      (clk),
    .rst      (rst),
    .run      (st == RINGING),
    .sec_tick (sec_tick),
    .tone_out (tone_out)
  );

endmodule

// File: tb/tb_alarm_trigger.sv
// Scoreboard bench for alarm_trigger: directed scenarios plus a random soak
// against a behavioural model; honours ALARM_CADENCE_EN when defined.
module tb_alarm_trigger;

  localparam int SNOOZE_MIN     = 1;
  localparam int RING_TIMEOUT_S = 5;
  localparam int MAX_SNOOZE     = 3;
  localparam int BEEP_DIV       = 4;
  localparam int NAP_S          = SNOOZE_MIN * 60;

  localparam int P_OFF = 0, P_WATCH = 1, P_RING = 2, P_NAP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ct, at;
  logic        tick, en, la, sn, dm;
  logic        ringing, snoozed, buzzer;
  logic [1:0]  snooze_cnt;

  always #5 clk = ~clk;

  alarm_trigger #(
    .SNOOZE_MIN(SNOOZE_MIN), .RING_TIMEOUT_S(RING_TIMEOUT_S),
    .MAX_SNOOZE(MAX_SNOOZE), .BEEP_DIV(BEEP_DIV)
  ) dut (
    .clk(clk), .rst(rst), .clock_time(ct), .alarm_time(at), .sec_tick(tick),
    .alarm_en(en), .load_active(la), .snooze(sn), .dismiss(dm),
    .ringing(ringing), .snoozed(snoozed), .buzzer(buzzer), .snooze_cnt(snooze_cnt)
  );

  typedef struct packed {
    logic       r;
    logic       s;
    logic       b;
    logic [1:0] n;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // behavioural model: which phase the alarm is in, plus plain counters
  int m_phase, m_secs, m_naps, m_rcyc, m_rticks;
  bit m_prev;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] need);
    n_cmp++;
    if (got !== need) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%b need=%b", name, $time, got, need);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("ring/snz/buzz/cnt", {ringing, snoozed, buzzer, snooze_cnt}, e);
    end
  end

  task automatic model_reset();
    m_phase = P_OFF; m_secs = 0; m_naps = 0; m_rcyc = 0; m_rticks = 0; m_prev = 0;
  endtask

  function automatic bit gate_on();
`ifdef ALARM_CADENCE_EN
    return (m_rticks % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: predict post-edge outputs from current inputs, push, advance.
  task automatic cyc();
    bit   match, rise;
    int   nph;
    exp_t e;
    match = (ct == at) && !la;
    rise  = match && !m_prev;
    e.r = (m_phase == P_RING);
    e.s = (m_phase == P_NAP);
    e.b = (m_phase == P_RING) && (((m_rcyc / BEEP_DIV) % 2) == 1) && gate_on();
    nph = m_phase;
    if (!en) begin
      nph = P_OFF; m_naps = 0;
    end else if (m_phase == P_OFF) begin
      nph = P_WATCH;
    end else if (m_phase == P_WATCH) begin
      if (rise) begin nph = P_RING; m_secs = 0; end
    end else if (m_phase == P_RING) begin
      if (dm) begin nph = P_WATCH; m_naps = 0; end
      else if (sn && m_naps < MAX_SNOOZE) begin nph = P_NAP; m_naps++; m_secs = 0; end
      else if (m_secs == RING_TIMEOUT_S) begin nph = P_WATCH; m_naps = 0; end
      else if (tick) m_secs++;
    end else begin
      if (dm) begin nph = P_WATCH; m_naps = 0; end
      else if (m_secs == NAP_S) begin nph = P_RING; m_secs = 0; end
      else if (tick) m_secs++;
    end
    if (m_phase == P_RING && nph == P_RING) begin
      m_rcyc++;
      if (tick) m_rticks++;
    end else begin
      m_rcyc = 0; m_rticks = 0;
    end
    e.n     = 2'(m_naps);
    m_prev  = match;
    m_phase = nph;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    tick = 0; sn = 0; dm = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic ticks(input int n, input int gmin, input int gmax);
    repeat (n) begin
      cycles($urandom_range(gmax, gmin));
      tick = 1;
      cyc();
    end
  endtask

  task automatic ring_up();
    ct = 16'h0729; cycles(2);
    ct = 16'h0730; cycles(3);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check("async_rst", {ringing, snoozed, buzzer, snooze_cnt}, 5'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; ct = 16'h0000; at = 16'h0730;
    tick = 0; en = 0; la = 0; sn = 0; dm = 0;
    model_reset();
    #1 check("reset_state", {ringing, snoozed, buzzer, snooze_cnt}, 5'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // basic ring, then dismiss
    en = 1; cycles(3);
    ring_up(); cycles(20);
    dm = 1; cyc(); cycles(4);

    // enable inside the match minute stays quiet; next occurrence rings
    en = 0; cycles(3);
    en = 1; cycles(12);
    ring_up(); cycles(6);
    dm = 1; cyc(); cycles(3);

    // timeout then no re-ring while the minute persists
    ring_up();
    ticks(RING_TIMEOUT_S, 1, 4);
    cycles(25);

    // snooze cycles up to the cap, 4th snooze ignored
    ring_up();
    repeat (MAX_SNOOZE) begin
      sn = 1; cyc(); cycles(2);
      ticks(NAP_S, 0, 2);
      cycles(3);
    end
    sn = 1; cyc(); cycles(5);
    dm = 1; cyc(); cycles(3);

    // snooze+dismiss together; disable during snooze; load suppresses match
    ring_up();
    sn = 1; dm = 1; cyc(); cycles(3);
    ring_up();
    sn = 1; cyc(); cycles(3);
    en = 0; cycles(3);
    en = 1; cycles(3);
    ct = 16'h0729; cycles(2);
    la = 1; cycles(1);
    ct = 16'h0730; cycles(6);
    ct = 16'h0731; cycles(2);
    la = 0; cycles(3);

    // asynchronous reset mid-ring with the buzzer on
    ring_up(); cycles(4);
    check("pre_rst_buzzer", {4'b0, buzzer}, 5'b1);
    async_reset();

    // cadence: regular seconds through a full timeout
    en = 1; cycles(3);
    ring_up();
    ticks(RING_TIMEOUT_S, 8, 8);
    cycles(6);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9, 0) == 0) begin
        case ($urandom_range(2, 0))
          0: ct = 16'h0729;
          1: ct = 16'h0730;
          default: ct = 16'h0731;
        endcase
      end
      en   = ($urandom_range(39, 0) != 0);
      la   = ($urandom_range(14, 0) == 0);
      tick = ($urandom_range(3, 0) == 0);
      sn   = ($urandom_range(11, 0) == 0);
      dm   = ($urandom_range(29, 0) == 0);
      cyc();
    end
    cycles(3);
    @(posedge clk); #3;

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, need 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
Consumer of the clock block's BCD time outputs (HH:MM, 4 digits × 4 bits).
- Compares current time against the stored alarm time.
- Runs the ring / snooze / dismiss state machine and drives a buzzer tone and status outputs.
- Sits between the clock block and board I/O (buzzer pin, LED, snooze and dismiss buttons).

Parameters:
SNOOZE_MIN, 5, snooze length in minutes; counted as SNOOZE_MIN*60 sec_tick pulses
RING_TIMEOUT_S, 60, seconds of ringing before auto-dismiss
MAX_SNOOZE, 3, snoozes allowed per alarm event; further snooze presses are ignored
BEEP_DIV, 50000, clk cycles per buzzer half-period (1 kHz at 100 MHz)

Ports:
clk  input  1  system clock; the only clock
rst  input  1  asynchronous, active-high reset
clock_time  input  16  current time in BCD {HR1,HR0,MIN1,MIN0}
alarm_time  input  16  alarm time in BCD, same layout
sec_tick  input  1  one-clk-wide pulse once per second, synchronous to clk
alarm_en  input  1  alarm armed switch (level)
load_active  input  1  clock or alarm load in progress; suppresses matching
snooze  input  1  debounced one-clk pulse
dismiss  input  1  debounced one-clk pulse
ringing  output  1  high while in RINGING
snoozed  output  1  high while in SNOOZE
buzzer  output  1  square-wave tone, registered
snooze_cnt  output  2  snoozes used in the current event

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE; ringing, snoozed, buzzer, snooze_cnt, tone and second counters all 0; match_q 0.
- Match detection:
  - match = (clock_time == alarm_time) && !load_active.
  - match_q is registered every cycle in every state.
  - A rise is match && !match_q.
  - Only a rise triggers, so enabling the alarm during a matching minute does not ring, and a dismissed alarm does not re-ring in the same minute.
- States: IDLE, ARMED, RINGING, SNOOZE.
- Transitions:
  - Any state with alarm_en=0: go to IDLE next cycle; snooze_cnt cleared. This has the highest priority after rst.
  - IDLE to ARMED when alarm_en=1.
  - ARMED to RINGING on a rise. The second counter is cleared.
  - RINGING:
    - dismiss: go to ARMED; snooze_cnt cleared.
    - Otherwise snooze with snooze_cnt<MAX_SNOOZE: go to SNOOZE; snooze_cnt incremented; second counter cleared.
    - Otherwise, when the second counter reaches RING_TIMEOUT_S (counted on sec_tick): go to ARMED; snooze_cnt cleared.
    - Snooze with snooze_cnt==MAX_SNOOZE: ignored.
  - SNOOZE:
    - dismiss: go to ARMED; snooze_cnt cleared.
    - When the second counter reaches SNOOZE_MIN*60: go to RINGING; second counter cleared.
    - Snooze pulses and rises are ignored.
- Simultaneous events:
  - dismiss beats snooze beats timeout.
  - When a transition and sec_tick land in the same cycle, the transition wins and the new state's counter starts at 0.
- Second counter: width $clog2(max(SNOOZE_MIN*60, RING_TIMEOUT_S)+1). It increments only on sec_tick and holds otherwise.
- Outputs: ringing and snoozed are registered decodes of the state. They go high the cycle after the state register changes.
- Latency: a rise sampled at edge N gives state RINGING after edge N and ringing high after edge N+1.
- Tone:
  - The divider counts 0..BEEP_DIV-1 and toggles the tone at wrap.
  - Divider and tone are held at 0 outside RINGING.
  - buzzer = registered (tone && gate) in RINGING, else 0.
- load_active: forces match low only. It does not leave RINGING or SNOOZE.
- rst mid-ring: buzzer and all outputs return to 0 immediately (asynchronous).

Optional Feature:
ALARM_CADENCE_EN
- Defined: gate toggles on each sec_tick while RINGING and starts at 1 on entry to RINGING. The tone is audible on alternate seconds (beep-pause cadence).
- Undefined: gate is constant 1 (continuous tone). No gate flop is synthesized.

Decomposition:
- Shared package alarm_pkg:
  - state enum (IDLE, ARMED, RINGING, SNOOZE, 2 bits);
  - BCD time typedef (16 bits) with digit field constants;
  - SEC_PER_MIN = 60.
- One natural sub-module: tone_gen. It holds the BEEP_DIV divider, tone flop and cadence gate, with inputs clk, rst, run, sec_tick and output tone_out.

Test Plan:
Bench parameters: SNOOZE_MIN=1, RING_TIMEOUT_S=5, BEEP_DIV=4.
1. Basic ring: alarm_en=1, alarm_time=16'h0730, clock_time steps 16'h0729 to 16'h0730. Required: ringing=1 two edges later; buzzer toggles every 4 clk.
2. Mid-minute enable: alarm_en rises while clock_time==alarm_time==16'h0730. Required: no ringing; ringing=1 next day when 16'h0729 to 16'h0730 recurs.
3. Timeout and no re-ring: ring, then 5 sec_tick pulses. Required: back to ARMED, ringing=0, buzzer=0; no re-ring while clock_time stays 16'h0730.
4. Snooze cycle and cap:
   - ring, snooze pulse: snoozed=1, snooze_cnt=1;
   - 60 sec_ticks: ringing=1;
   - repeat until snooze_cnt=3; a 4th snooze is ignored, ringing stays 1.
5. Priority and overrides:
   - snooze and dismiss in the same cycle: ARMED, snooze_cnt=0;
   - alarm_en=0 during SNOOZE: IDLE next cycle;
   - load_active=1 during the match minute edge: no ring.
6. Reset and cadence:
   - rst asserted mid-ring, asynchronous to clk: ringing, buzzer and snooze_cnt go to 0 without waiting for an edge.
   - With ALARM_CADENCE_EN defined: buzzer is active during seconds 0, 2 and 4 of ringing and silent during seconds 1 and 3.
